// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures ROM words into an instruction register and
// hands them to decode over valid/ready, with branch redirect, stall and HALT handling.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'd0,
   parameter logic [15:0] PC_LAST     = 16'hFFFF,
   parameter logic [3:0]  HALT_OPCODE = 4'b1011
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] pc_out,
   input  logic        rom_format,
   input  logic [3:0]  rom_opcode,
   input  logic        rom_sign,
   input  logic [2:0]  rom_operand,
   input  logic [7:0]  rom_immediate,
   input  logic        br_valid,
   input  logic [15:0] br_target,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [8:0]  ir_instr,
   output logic [15:0] ir_pc,
   output logic        halted,
   output logic [15:0] fetch_count
);

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_HALT_PEND = 2'd1;
   localparam logic [1:0] ST_HALTED    = 2'd2;

   logic [1:0]  state;
   logic [8:0]  rom_word;
   logic        rom_is_halt;
   logic [15:0] pc_next;
   logic        load;
   logic        accept;

   // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      rom_word    = rom_format ? {1'b1, rom_opcode, rom_sign, rom_operand}
                               : {1'b0, rom_immediate};
      rom_is_halt = rom_format && (rom_opcode == HALT_OPCODE) && !rom_sign
                    && (rom_operand == 3'd0);
      pc_next     = (pc_out == PC_LAST) ? RESET_PC : pc_out + 16'd1;
      accept      = ir_valid && ir_ready;
      load        = !ir_valid || ir_ready;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out      <= RESET_PC;
         ir_valid    <= 1'b0;
         ir_instr    <= 9'd0;
         ir_pc       <= 16'd0;
         halted      <= 1'b0;
         fetch_count <= 16'd0;
         state       <= ST_RUN;
      end else begin
         if (accept && (fetch_count != 16'hFFFF))
            fetch_count <= fetch_count + 16'd1;

         case (state)
            ST_RUN: begin
               // Redirect wins over both load and stall; the ROM is only sampled on load.
               if (br_valid) begin
                  pc_out   <= br_target;
                  ir_valid <= 1'b0;
               end else if (load) begin
                  ir_instr <= rom_word;
                  ir_pc    <= pc_out;
                  ir_valid <= 1'b1;
                  pc_out   <= pc_next;
                  if (rom_is_halt)
                     state <= ST_HALT_PEND;
               end
            end
            ST_HALT_PEND: begin
               if (accept) begin
                  ir_valid <= 1'b0;
                  halted   <= 1'b1;
                  state    <= ST_HALTED;
               end
            end
            default: begin
               // Halted: everything frozen until reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level fetch model compared every cycle, plus
// directed vectors with hand-computed expectations.
module tb_instr_fetch_unit;

   localparam logic [15:0] PC_LAST_TB = 16'd7;
   localparam logic [8:0]  HALT_WORD  = 9'b110110000;

   logic        clk;
   logic        reset;
   logic [15:0] pc_out;
   logic        rom_format;
   logic [3:0]  rom_opcode;
   logic        rom_sign;
   logic [2:0]  rom_operand;
   logic [7:0]  rom_immediate;
   logic        br_valid;
   logic [15:0] br_target;
   logic        ir_valid;
   logic        ir_ready;
   logic [8:0]  ir_instr;
   logic [15:0] ir_pc;
   logic        halted;
   logic [15:0] fetch_count;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   bit rom_x = 1'b0;
   logic [8:0] rom [0:63];

   instr_fetch_unit #(
      .RESET_PC(16'd0), .PC_LAST(PC_LAST_TB), .HALT_OPCODE(4'b1011)
   ) dut (
      .clk(clk), .reset(reset), .pc_out(pc_out),
      .rom_format(rom_format), .rom_opcode(rom_opcode), .rom_sign(rom_sign),
      .rom_operand(rom_operand), .rom_immediate(rom_immediate),
      .br_valid(br_valid), .br_target(br_target),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ROM: splits the stored word into fields; unused fields are driven X.
   always_comb begin
      logic [8:0] w;
      w = rom[pc_out[5:0]];
      rom_format    = w[8];
      rom_opcode    = w[8] ? w[7:4] : 4'bx;
      rom_sign      = w[8] ? w[3]   : 1'bx;
      rom_operand   = w[8] ? w[2:0] : 3'bx;
      rom_immediate = w[8] ? 8'bx   : w[7:0];
      if (rom_x) begin
         rom_format    = 1'bx;
         rom_opcode    = 4'bx;
         rom_sign      = 1'bx;
         rom_operand   = 3'bx;
         rom_immediate = 8'bx;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: fetch is a stream of ROM addresses; decode consumes one instruction per accept.
   logic [15:0] m_pc, m_ir_pc, m_count;
   logic [8:0]  m_instr;
   logic        m_valid, m_pending, m_halted, m_acc;
   assign m_acc = m_valid && ir_ready;

   always @(posedge clk) begin
      if (reset) begin
         m_pc <= 16'd0; m_valid <= 1'b0; m_instr <= 9'd0; m_ir_pc <= 16'd0;
         m_count <= 16'd0; m_pending <= 1'b0; m_halted <= 1'b0;
      end else begin
         if (m_acc && m_count != 16'hFFFF) m_count <= m_count + 16'd1;
         if (m_halted) begin
         end else if (m_pending) begin
            if (m_acc) begin
               m_valid <= 1'b0; m_halted <= 1'b1; m_pending <= 1'b0;
            end
         end else if (br_valid) begin
            m_pc <= br_target; m_valid <= 1'b0;
         end else if (!m_valid || ir_ready) begin
            m_instr   <= rom[m_pc[5:0]];
            m_ir_pc   <= m_pc;
            m_valid   <= 1'b1;
            m_pc      <= (m_pc == PC_LAST_TB) ? 16'd0 : m_pc + 16'd1;
            m_pending <= (rom[m_pc[5:0]] == HALT_WORD);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_pc_out", pc_out, m_pc);
         check("model_ir_valid", ir_valid, m_valid);
         check("model_halted", halted, m_halted);
         check("model_fetch_count", fetch_count, m_count);
         if (m_valid) begin
            check("model_ir_pc", ir_pc, m_ir_pc);
            check("model_ir_instr", ir_instr, m_instr);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ir_ready = 1'b0; br_valid = 1'b0; br_target = 16'd0;
      for (int i = 0; i < 64; i++) rom[i] = 9'(i);
      rom[12] = HALT_WORD;
      rom[20] = 9'b000000010;
      rom[21] = 9'b100001011;

      @(posedge clk);
      chk_en = 1'b1;
      tick();
      check("rst_pc_out", pc_out, 16'd0);
      check("rst_ir_valid", ir_valid, 1'b0);
      check("rst_ir_instr", ir_instr, 9'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_fetch_count", fetch_count, 16'd0);

      // Ramp with decode always ready
      reset = 1'b0; ir_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ramp_ir_valid", ir_valid, 1'b1);
         check("ramp_ir_pc", ir_pc, 32'(i));
         check("ramp_ir_instr", ir_instr, 32'(i));
         check("ramp_count", fetch_count, 32'(i));
      end

      // Stall three cycles at ir_pc 5 with garbage on the ROM
      tick();
      check("stall_entry_ir_pc", ir_pc, 16'd5);
      ir_ready = 1'b0; rom_x = 1'b1;
      repeat (3) begin
         tick();
         check("stall_ir_pc", ir_pc, 16'd5);
         check("stall_ir_instr", ir_instr, 9'd5);
         check("stall_pc_out", pc_out, 16'd6);
         check("stall_count", fetch_count, 16'd5);
      end
      ir_ready = 1'b1; rom_x = 1'b0;

      // Resume and wrap at PC_LAST
      tick(); check("resume_ir_pc6", ir_pc, 16'd6);
      check("resume_count", fetch_count, 16'd6);
      tick(); check("wrap_ir_pc7", ir_pc, 16'd7);
      check("wrap_pc_out", pc_out, 16'd0);
      tick(); check("wrap_ir_pc0", ir_pc, 16'd0);
      tick(); check("wrap_ir_pc1", ir_pc, 16'd1);

      // Branch coinciding with an accept: flush, but the accept counts
      br_valid = 1'b1; br_target = 16'd9;
      tick();
      check("br9_ir_valid", ir_valid, 1'b0);
      check("br9_pc_out", pc_out, 16'd9);
      check("br9_count", fetch_count, 16'd10);
      br_valid = 1'b0; ir_ready = 1'b0;
      tick();
      check("br9_ir_pc", ir_pc, 16'd9);
      check("br9_pc_next", pc_out, 16'd10);

      // Branch while stalled
      br_valid = 1'b1; br_target = 16'd40;
      tick();
      check("br40_flush", ir_valid, 1'b0);
      check("br40_pc_out", pc_out, 16'd40);
      check("br40_count", fetch_count, 16'd10);
      br_valid = 1'b0; ir_ready = 1'b1;
      tick();
      check("br40_ir_pc", ir_pc, 16'd40);
      check("br40_ir_instr", ir_instr, 9'd40);

      // Immediate and register forms
      br_valid = 1'b1; br_target = 16'd20;
      tick();
      check("br20_count", fetch_count, 16'd11);
      br_valid = 1'b0;
      tick(); check("imm_form", ir_instr, 9'h002);
      tick(); check("reg_form", ir_instr, 9'h10B);
      check("reg_form_pc", ir_pc, 16'd21);

      // HALT
      br_valid = 1'b1; br_target = 16'd12;
      tick(); check("br12_pc_out", pc_out, 16'd12);
      br_valid = 1'b0; ir_ready = 1'b0;
      tick();
      check("halt_ir_instr", ir_instr, 9'h1B0);
      check("halt_ir_pc", ir_pc, 16'd12);
      check("halt_pc_out", pc_out, 16'd13);
      br_valid = 1'b1; br_target = 16'd30;
      tick();
      check("halt_pend_pc_out", pc_out, 16'd13);
      check("halt_pend_valid", ir_valid, 1'b1);
      check("halt_pend_halted", halted, 1'b0);
      ir_ready = 1'b1;
      tick();
      check("halt_halted", halted, 1'b1);
      check("halt_ir_valid", ir_valid, 1'b0);
      check("halt_count", fetch_count, 16'd14);
      repeat (3) begin
         tick();
         check("halted_pc_out", pc_out, 16'd13);
         check("halted_count", fetch_count, 16'd14);
      end

      // Reset out of HALTED, then reset mid-run at pc 4
      br_valid = 1'b0; reset = 1'b1;
      tick();
      check("rst2_halted", halted, 1'b0);
      check("rst2_pc_out", pc_out, 16'd0);
      reset = 1'b0;
      repeat (4) tick();
      check("run_ir_pc3", ir_pc, 16'd3);
      check("run_pc_out4", pc_out, 16'd4);
      reset = 1'b1;
      tick();
      check("rst3_pc_out", pc_out, 16'd0);
      check("rst3_ir_valid", ir_valid, 1'b0);
      check("rst3_count", fetch_count, 16'd0);
      reset = 1'b0;
      tick();
      check("post_rst_ir_pc", ir_pc, 16'd0);
      check("post_rst_valid", ir_valid, 1'b1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
